regfile_mp: RTL

- Parametrised multi-port integer register file for the xgriscv pipeline; replaces the single-write, two-read negedge register file.
- Adds:
  - configurable read and write port counts;
  - same-cycle write-to-read bypass;
  - synchronous posedge writes;
  - asynchronous clear;
  - a per-register pending-write scoreboard that lets hazard logic stall on long-latency producers such as loads and multi-cycle multiply/divide.
- Sits in the decode stage; write ports are driven from WB and from the long-latency unit.

---
 rtl/regfile_mp_pkg.sv | 13 +
 rtl/regfile_mp_if.sv | 26 ++
 rtl/regfile_mp_scoreboard.sv | 50 +++++
 rtl/regfile_mp.sv | 79 +++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared widths and helpers for the multi-port integer register file.
package regfile_mp_pkg;
  localparam int RF_XLEN = 32;
  localparam int RF_NREG = 32;
  localparam int RF_NR   = 2;
  localparam int RF_NW   = 2;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// Decode-stage bus of the register file: read ports, write ports, scoreboard.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int NREG = RF_NREG,
  parameter int IDXW = $clog2(NREG),
  parameter int NR   = RF_NR,
  parameter int NW   = RF_NW
);
  logic [NR*IDXW-1:0] ra;
  logic [NR*XLEN-1:0] rd;
  logic [NR-1:0]      rbusy;
  logic [NW-1:0]      we;
  logic [NW*IDXW-1:0] wa;
  logic [NW*XLEN-1:0] wd;
  logic               sb_set;
  logic [IDXW-1:0]    sb_wa;
  logic [NREG-1:0]    sb_busy;
  logic [31:0]        wr_cnt;

  modport master (output ra, we, wa, wd, sb_set, sb_wa,
                  input  rd, rbusy, sb_busy, wr_cnt);
  modport slave  (input  ra, we, wa, wd, sb_set, sb_wa,
                  output rd, rbusy, sb_busy, wr_cnt);
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write scoreboard: a new producer (set) outranks a retiring write (clear).
module regfile_mp_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int NREG = RF_NREG,
  parameter int IDXW = $clog2(NREG),
  parameter int NR   = RF_NR,
  parameter int NW   = RF_NW
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_sb_set,
  input  logic [IDXW-1:0]    i_sb_wa,
  input  logic [NW-1:0]      i_we,
  input  logic [NW*IDXW-1:0] i_wa,
  input  logic [NR*IDXW-1:0] i_ra,
  output logic [NREG-1:0]    o_busy,
  output logic [NR-1:0]      o_rbusy
);
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_next;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_sb_set) w_set[i_sb_wa] = 1'b1;
    for (int j = 0; j < NW; j++) begin
      if (i_we[j]) w_clr[i_wa[j*IDXW +: IDXW]] = 1'b1;
    end
    w_next    = (r_busy & ~w_clr) | w_set;
    w_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_busy <= '0;
    else       r_busy <= w_next;
  end

  // A retiring write releases the stall in the cycle its data is bypassed.
  always_comb begin
    o_rbusy = '0;
    for (int i = 0; i < NR; i++) begin
      o_rbusy[i] = r_busy[i_ra[i*IDXW +: IDXW]] && !w_clr[i_ra[i*IDXW +: IDXW]];
    end
  end

  assign o_busy = r_busy;
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass, x0 hardwired to zero,
// saturating committed-write counter and a pending-write scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int NREG = RF_NREG,
  parameter int IDXW = $clog2(NREG),
  parameter int NR   = RF_NR,
  parameter int NW   = RF_NW
) (
  input logic         clk,
  input logic         rstn,
  regfile_mp_if.slave bus
);
  logic [XLEN-1:0] r_rf [NREG];
  logic [31:0]     r_wr_cnt;
  logic [NW-1:0]   w_win;
  logic [31:0]     w_nwin;
  logic [NR*XLEN-1:0] w_rd;

  // A port wins only if no higher-index port targets the same register.
  always_comb begin
    w_win  = '0;
    w_nwin = '0;
    for (int j = 0; j < NW; j++) begin
      w_win[j] = bus.we[j] && (bus.wa[j*IDXW +: IDXW] != '0);
      for (int k = j + 1; k < NW; k++) begin
        if (bus.we[k] && (bus.wa[k*IDXW +: IDXW] == bus.wa[j*IDXW +: IDXW])) w_win[j] = 1'b0;
      end
      if (w_win[j]) w_nwin = w_nwin + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < NREG; r++) r_rf[r] <= '0;
      r_wr_cnt <= '0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (w_win[j]) r_rf[bus.wa[j*IDXW +: IDXW]] <= bus.wd[j*XLEN +: XLEN];
      end
      r_wr_cnt <= sat_add32(r_wr_cnt, w_nwin);
    end
  end

  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NR; i++) begin
      if (bus.ra[i*IDXW +: IDXW] != '0) begin
        w_rd[i*XLEN +: XLEN] = r_rf[bus.ra[i*IDXW +: IDXW]];
        for (int j = 0; j < NW; j++) begin
          if (bus.we[j] && (bus.wa[j*IDXW +: IDXW] == bus.ra[i*IDXW +: IDXW]))
            w_rd[i*XLEN +: XLEN] = bus.wd[j*XLEN +: XLEN];
        end
      end
    end
  end

  assign bus.rd     = w_rd;
  assign bus.wr_cnt = r_wr_cnt;

  regfile_mp_scoreboard #(
    .NREG (NREG),
    .IDXW (IDXW),
    .NR   (NR),
    .NW   (NW)
  ) u_sb (
    .clk      (clk),
    .rstn     (rstn),
    .i_sb_set (bus.sb_set),
    .i_sb_wa  (bus.sb_wa),
    .i_we     (bus.we),
    .i_wa     (bus.wa),
    .i_ra     (bus.ra),
    .o_busy   (bus.sb_busy),
    .o_rbusy  (bus.rbusy)
  );
endmodule
